// File: rtl/sap_sequencer.sv
// SAP-II variable-length instruction sequencer: T-state timing plus per-state control decode.
// Optional illegal-opcode trap enabled by defining ILLEGAL_TRAP_EN (default build: unknown opcodes run as NOP).
module sap_sequencer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       run_i,
    input  logic [7:0] opcode_i,
    output logic [5:0] t_o,
    output logic       pc_oe_o,
    output logic       pc_inc_o,
    output logic       mar_ld_o,
    output logic       mem_oe_o,
    output logic       ir_ld_o,
    output logic       a_ld_o,
    output logic       a_oe_o,
    output logic       b_ld_o,
    output logic       b_oe_o,
    output logic       alu_oe_o,
    output logic       alu_sub_o,
    output logic       out_ld_o,
    output logic       eoi_o,
    output logic       hlt_o,
    output logic       illegal_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T0   = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;
    localparam logic [2:0] ST_T5   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_MOV_BA = 8'h47;
    localparam logic [7:0] OP_ADD    = 8'h80;
    localparam logic [7:0] OP_SUB    = 8'h90;
    localparam logic [7:0] OP_MVI    = 8'h3E;
    localparam logic [7:0] OP_OUT    = 8'hD3;
    localparam logic [7:0] OP_HLT    = 8'h76;

    logic [2:0] state_q, state_d;
    logic [7:0] op_q, op_d;

    logic is_long;
    logic trap_op;
    logic ends_in_halt;
    logic [2:0] end_state;

    // op_q keeps the opcode through HALT, so a trapped halt is recognised from op_q alone.
    always_comb begin
        is_long = (op_q == OP_MVI) || (op_q == OP_OUT);
`ifdef ILLEGAL_TRAP_EN
        trap_op = !((op_q == OP_NOP)    || (op_q == OP_MOV_AB) ||
                    (op_q == OP_MOV_BA) || (op_q == OP_ADD)    ||
                    (op_q == OP_SUB)    || (op_q == OP_MVI)    ||
                    (op_q == OP_OUT)    || (op_q == OP_HLT));
`else
        trap_op = 1'b0;
`endif
        ends_in_halt = (op_q == OP_HLT) || trap_op;
        end_state    = run_i ? ST_T0 : ST_IDLE;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (clr_i) begin
            state_d = ST_IDLE;
            op_d    = OP_NOP;
        end else begin
            case (state_q)
                ST_IDLE: state_d = run_i ? ST_T0 : ST_IDLE;
                ST_T0:   state_d = ST_T1;
                ST_T1:   state_d = ST_T2;
                ST_T2: begin
                    state_d = ST_T3;
                    op_d    = opcode_i;
                end
                ST_T3: begin
                    if (is_long)
                        state_d = ST_T4;
                    else if (ends_in_halt)
                        state_d = ST_HALT;
                    else
                        state_d = end_state;
                end
                ST_T4:   state_d = ST_T5;
                ST_T5:   state_d = end_state;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer advances on the falling edge so controls are settled at the datapath's rising edge.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_tstate
            assign t_o[gi] = (state_q == 3'(gi + 1));
        end
    endgenerate

    always_comb begin
        pc_oe_o   = 1'b0;
        pc_inc_o  = 1'b0;
        mar_ld_o  = 1'b0;
        mem_oe_o  = 1'b0;
        ir_ld_o   = 1'b0;
        a_ld_o    = 1'b0;
        a_oe_o    = 1'b0;
        b_ld_o    = 1'b0;
        b_oe_o    = 1'b0;
        alu_oe_o  = 1'b0;
        alu_sub_o = 1'b0;
        out_ld_o  = 1'b0;
        eoi_o     = 1'b0;
        hlt_o     = 1'b0;
        illegal_o = 1'b0;
        case (state_q)
            ST_T0: begin
                pc_oe_o  = 1'b1;
                mar_ld_o = 1'b1;
            end
            ST_T1: pc_inc_o = 1'b1;
            ST_T2: begin
                mem_oe_o = 1'b1;
                ir_ld_o  = 1'b1;
            end
            ST_T3: begin
                eoi_o = !is_long;
                case (op_q)
                    OP_MOV_AB: begin
                        b_oe_o = 1'b1;
                        a_ld_o = 1'b1;
                    end
                    OP_MOV_BA: begin
                        a_oe_o = 1'b1;
                        b_ld_o = 1'b1;
                    end
                    OP_ADD: begin
                        alu_oe_o = 1'b1;
                        a_ld_o   = 1'b1;
                    end
                    OP_SUB: begin
                        alu_oe_o  = 1'b1;
                        a_ld_o    = 1'b1;
                        alu_sub_o = 1'b1;
                    end
                    OP_MVI, OP_OUT: begin
                        pc_oe_o  = 1'b1;
                        mar_ld_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: pc_inc_o = is_long;
            ST_T5: begin
                eoi_o = 1'b1;
                // OUT skips its port byte: the operand fetch only advances the PC.
                if (op_q == OP_OUT) begin
                    a_oe_o   = 1'b1;
                    out_ld_o = 1'b1;
                end else begin
                    mem_oe_o = 1'b1;
                    a_ld_o   = 1'b1;
                end
            end
            ST_HALT: begin
                hlt_o     = 1'b1;
                illegal_o = trap_op;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_sequencer.sv
// Scoreboard bench for sap_sequencer: stimulus queues expected per-cycle output vectors,
// a monitor pops and compares them mid-state (rising edge + 1).
module tb_sap_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i, clr_i, run_i;
    logic [7:0] opcode_i;
    logic [5:0] t_o;
    logic pc_oe_o, pc_inc_o, mar_ld_o, mem_oe_o, ir_ld_o, a_ld_o, a_oe_o, b_ld_o;
    logic b_oe_o, alu_oe_o, alu_sub_o, out_ld_o, eoi_o, hlt_o, illegal_o;

    localparam logic [14:0] C_NONE    = 15'h0000;
    localparam logic [14:0] C_PC_OE   = 15'h4000;
    localparam logic [14:0] C_PC_INC  = 15'h2000;
    localparam logic [14:0] C_MAR_LD  = 15'h1000;
    localparam logic [14:0] C_MEM_OE  = 15'h0800;
    localparam logic [14:0] C_IR_LD   = 15'h0400;
    localparam logic [14:0] C_A_LD    = 15'h0200;
    localparam logic [14:0] C_A_OE    = 15'h0100;
    localparam logic [14:0] C_B_LD    = 15'h0080;
    localparam logic [14:0] C_B_OE    = 15'h0040;
    localparam logic [14:0] C_ALU_OE  = 15'h0020;
    localparam logic [14:0] C_ALU_SUB = 15'h0010;
    localparam logic [14:0] C_OUT_LD  = 15'h0008;
    localparam logic [14:0] C_EOI     = 15'h0004;
    localparam logic [14:0] C_HLT     = 15'h0002;
    localparam logic [14:0] C_ILL     = 15'h0001;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];
    string       tag_q[$];
    event        sample_ev;
    logic [20:0] act;

    sap_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .run_i(run_i), .opcode_i(opcode_i),
        .t_o(t_o), .pc_oe_o(pc_oe_o), .pc_inc_o(pc_inc_o), .mar_ld_o(mar_ld_o),
        .mem_oe_o(mem_oe_o), .ir_ld_o(ir_ld_o), .a_ld_o(a_ld_o), .a_oe_o(a_oe_o),
        .b_ld_o(b_ld_o), .b_oe_o(b_oe_o), .alu_oe_o(alu_oe_o), .alu_sub_o(alu_sub_o),
        .out_ld_o(out_ld_o), .eoi_o(eoi_o), .hlt_o(hlt_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    assign act = {t_o, pc_oe_o, pc_inc_o, mar_ld_o, mem_oe_o, ir_ld_o, a_ld_o, a_oe_o,
                  b_ld_o, b_oe_o, alu_oe_o, alu_sub_o, out_ld_o, eoi_o, hlt_o, illegal_o};

    task automatic push(input logic [5:0] t, input logic [14:0] c, input string tag);
        exp_q.push_back({t, c});
        tag_q.push_back(tag);
    endtask

    task automatic push_fetch(input string name);
        push(6'b000001, C_PC_OE | C_MAR_LD, {name, "_T0"});
        push(6'b000010, C_PC_INC,           {name, "_T1"});
        push(6'b000100, C_MEM_OE | C_IR_LD, {name, "_T2"});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Monitor: one compare per presented sample while expectations are pending.
    initial begin : monitor
        logic [20:0] e;
        string tg;
        forever begin
            @(posedge clk_i or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", tg, act, e);
                end else begin
                    $display("ok   %s: %h", tg, act);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_i = 1'b1; clr_i = 1'b0; run_i = 1'b0; opcode_i = 8'h00;
        #2;
        push(6'b0, C_NONE, "reset_0");
        push(6'b0, C_NONE, "reset_1");
        step(2);

        // Stream MVI, ADD, OUT, HLT back to back, then 20 cycles of HALT.
        rst_i = 1'b0; run_i = 1'b1; opcode_i = 8'h3E;
        push_fetch("mvi");
        push(6'b001000, C_PC_OE | C_MAR_LD,      "mvi_T3");
        push(6'b010000, C_PC_INC,                "mvi_T4");
        push(6'b100000, C_MEM_OE | C_A_LD | C_EOI, "mvi_T5");
        push_fetch("add");
        push(6'b001000, C_ALU_OE | C_A_LD | C_EOI, "add_T3");
        push_fetch("out");
        push(6'b001000, C_PC_OE | C_MAR_LD,      "out_T3");
        push(6'b010000, C_PC_INC,                "out_T4");
        push(6'b100000, C_A_OE | C_OUT_LD | C_EOI, "out_T5");
        push_fetch("hlt");
        push(6'b001000, C_EOI, "hlt_T3");
        for (int i = 0; i < 20; i++) push(6'b0, C_HLT, "halt_hold");
        step(6);
        opcode_i = 8'h80; step(4);
        opcode_i = 8'hD3; step(6);
        opcode_i = 8'h76; step(4);
        step(20);

        // clr leaves HALT.
        clr_i = 1'b1; run_i = 1'b0;
        push(6'b0, C_NONE, "clr_idle");
        step(1);
        clr_i = 1'b0;

        // MVI with run dropped in T4, then SUB / MOV B,A.
        run_i = 1'b1; opcode_i = 8'h3E;
        push_fetch("mvi2");
        push(6'b001000, C_PC_OE | C_MAR_LD,        "mvi2_T3");
        push(6'b010000, C_PC_INC,                  "mvi2_T4");
        push(6'b100000, C_MEM_OE | C_A_LD | C_EOI, "mvi2_T5");
        push(6'b0, C_NONE, "idle_after_mvi2_0");
        push(6'b0, C_NONE, "idle_after_mvi2_1");
        push_fetch("sub");
        push(6'b001000, C_ALU_OE | C_A_LD | C_ALU_SUB | C_EOI, "sub_T3");
        push_fetch("movba");
        push(6'b001000, C_A_OE | C_B_LD | C_EOI, "movba_T3");
        push(6'b0, C_NONE, "idle_after_movba");
        step(5);
        run_i = 1'b0; step(3);
        run_i = 1'b1; opcode_i = 8'h90; step(4);
        opcode_i = 8'h47; step(3);
        run_i = 1'b0; step(2);

        // Async reset between edges during MVI T4.
        run_i = 1'b1; opcode_i = 8'h3E;
        push_fetch("mvi3");
        push(6'b001000, C_PC_OE | C_MAR_LD, "mvi3_T3");
        push(6'b010000, C_PC_INC,           "mvi3_T4");
        step(5);
        #1;
        rst_i = 1'b1;
        push(6'b0, C_NONE, "async_rst");
        ->sample_ev;
        #2;
        run_i = 1'b0;
        push(6'b0, C_NONE, "rst_hold");
        step(1);
        rst_i = 1'b0;
        #1;
        checks++;
        if (dut.op_q !== 8'h00) begin
            errors++;
            $display("FAIL op_q_after_rst: got %h expected 00", dut.op_q);
        end else begin
            $display("ok   op_q_after_rst: %h", dut.op_q);
        end
        push(6'b0, C_NONE, "idle_after_rst");
        step(1);

        // Undefined opcode 0xFF.
        run_i = 1'b1; opcode_i = 8'hFF;
`ifdef ILLEGAL_TRAP_EN
        push_fetch("ill");
        push(6'b001000, C_EOI, "ill_T3");
        for (int i = 0; i < 3; i++) push(6'b0, C_HLT | C_ILL, "ill_halt");
        push(6'b0, C_NONE, "ill_clr_0");
        push(6'b0, C_NONE, "ill_clr_1");
        step(7);
        clr_i = 1'b1; run_i = 1'b0;
        step(1);
        clr_i = 1'b0;
        step(1);
`else
        push_fetch("ill");
        push(6'b001000, C_EOI, "ill_T3");
        push_fetch("ill2");
        push(6'b001000, C_EOI, "ill2_T3");
        push(6'b0, C_NONE, "idle_after_ill");
        step(6);
        run_i = 1'b0;
        step(2);
`endif

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Variable-length instruction sequencer for the SAP-II datapath. It generates the T-state timing and decodes the instruction register opcode into per-state control signals for the PC, MAR, memory, IR, A, B, ALU and output port. Instructions end as soon as their last micro-step completes; the fixed six-state ring is not used. The block also provides run/idle gating, halt, and an optional illegal-opcode trap.

## Interface
- No parameters.
- clk  in  1  system clock; sequencer state changes on the falling edge, datapath loads on the rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous restart, sampled on the falling edge
- run  in  1  permit starting a new instruction
- opcode  in  8  IR contents
- T  out  6  one-hot current T-state, T[0]=T0; 6'b000000 in IDLE/HALT
- pc_oe, pc_inc, mar_ld, mem_oe, ir_ld  out  1 each  fetch/operand controls
- a_ld, a_oe, b_ld, b_oe, alu_oe, alu_sub, out_ld  out  1 each  execute controls
- eoi  out  1  high during the final T-state of each instruction
- hlt  out  1  high in HALT
- illegal  out  1  high in HALT when HALT was entered by the trap

## Operation
- States: IDLE, T0–T5, HALT.
- Registered: state and op_q (8 b). Controls, T, eoi, hlt and illegal decode combinationally from state and op_q.
- Fetch:
  - T0: pc_oe, mar_ld.
  - T1: pc_inc.
  - T2: mem_oe, ir_ld.
- op_q captures opcode on the falling edge that leaves T2.
- Execute by op_q:
  - 0x00 NOP: T3 with no controls.
  - 0x78 MOV A,B: T3 b_oe, a_ld.
  - 0x47 MOV B,A: T3 a_oe, b_ld.
  - 0x80 ADD B: T3 alu_oe, a_ld, alu_sub=0.
  - 0x90 SUB B: T3 alu_oe, a_ld, alu_sub=1.
  - 0x3E MVI A: T3 pc_oe, mar_ld; T4 pc_inc; T5 mem_oe, a_ld.
  - 0xD3 OUT: T3 pc_oe, mar_ld; T4 pc_inc; T5 a_oe, out_ld. The port byte is skipped.
  - 0x76 HLT: T3 with no controls, then HALT.
  - Any other opcode: see Configuration.
- Transitions:
  - IDLE → T0 if run, else stay in IDLE.
  - T0 → T1 → T2 → T3.
  - T3 → T4 for MVI/OUT.
  - T3 → HALT for HLT (and for trapped opcodes).
  - T3 → T0/IDLE for all other opcodes.
  - T4 → T5.
  - T5 → T0/IDLE.
  - The T0/IDLE choice at instruction end is run ? T0 : IDLE.
  - HALT → HALT. Only rst or clr leave HALT.
- eoi is high in T3 for 4-state instructions (NOP/MOV/ADD/SUB/HLT/untrapped unknown) and in T5 for MVI/OUT.
- Lengths: 4 states for single-byte instructions, 6 for MVI/OUT.
- run is sampled only at IDLE and at instruction end. Dropping run mid-instruction does not truncate the instruction.

## Timing
- rst asserted (any time, including mid-instruction or in HALT): state=IDLE and op_q=0x00 immediately.
  - While in reset, all outputs are 0: T=0, all controls 0, eoi=0, hlt=0, illegal=0.
- clr=1 at a falling edge: state=IDLE, op_q=0x00, illegal cleared. clr has priority over all transitions.
- rst released with run=1: the first falling edge enters T0.
- Each T-state lasts exactly one clock period, from falling edge to falling edge. Controls are therefore stable across the rising edge inside the state.
- Back-to-back instructions have no gap: T3/T5 is followed directly by T0 when run=1.
- The opcode must be stable from the rising edge in T2 through the following falling edge.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An undefined opcode executes T3 with no controls and eoi=1, then enters HALT with hlt=1, illegal=1.
  - illegal stays 1 until rst or clr.
- ILLEGAL_TRAP_EN undefined:
  - An undefined opcode behaves exactly as NOP.
  - illegal is tied to 0.

## Test plan
- Reset and start: rst pulse, run=1 → T = 000001, 000010, 000100, 001000 on successive falling edges; all outputs 0 during reset.
- Opcode stream 0x3E, 0x80, 0xD3, 0x76 with run=1:
  - State counts are 6, 4, 6, 4 with no gaps.
  - alu_sub=0 in ADD T3.
  - out_ld only in OUT T5.
  - hlt=1 after the HLT T3 and held for 20 cycles.
- run dropped during MVI T4 → T5 completes with mem_oe=a_ld=1, then IDLE (T=0). Raising run → T0 on the next falling edge.
- Async rst asserted between edges during MVI T4 → T=0 and all controls 0 immediately. After release, op_q=0x00.
- Opcode 0xFF:
  - With ILLEGAL_TRAP_EN: HALT, illegal=1; clr → IDLE, illegal=0.
  - Without ILLEGAL_TRAP_EN: 4-state NOP, then T0.
- 0x90 SUB B then 0x47 MOV B,A → SUB T3: alu_oe=a_ld=alu_sub=1. MOV T3: a_oe=b_ld=1, alu_sub=0. eoi high in each T3 only.
